stopwatch_btn_ctrl: RTL and testbench



---
 rtl/stopwatch_pkg.sv | 21 ++
 rtl/btn_debounce.sv | 69 ++++++
 rtl/stopwatch_btn_ctrl.sv | 120 ++++++++++++
 tb/tb_stopwatch_btn_ctrl.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch button front end.
// Holds the pause FSM encoding and the debounce length constants used
// by the hardware build and by short simulation runs.
package stopwatch_pkg;

  // Pause FSM state encoding; the state bit doubles as the paused indicator.
  typedef enum logic {
    RUN    = 1'b0,
    PAUSED = 1'b1
  } pause_state_e;

  // 5 ms of stable input at 100 MHz.
  localparam int DEB_CYCLES_DEFAULT  = 500000;

  // Short debounce window so simulations finish quickly.
  localparam int DEB_CYCLES_SIM      = 4;

  // Two flops are the minimum for a safe metastability margin.
  localparam int SYNC_STAGES_DEFAULT = 2;

endpackage : stopwatch_pkg

// File: rtl/btn_debounce.sv
// Synchroniser plus debouncer for one raw board input.
// The raw level passes through a SYNC_STAGES flop chain. A new level is
// accepted only after it has held for DEB_CYCLES consecutive clocks; any
// bounce back to the accepted level restarts the count from zero.
// 'rise' flags the cycle in which the accepted level has just gone high.
module btn_debounce
  import stopwatch_pkg::*;
#(
  parameter int DEB_CYCLES  = DEB_CYCLES_DEFAULT,
  parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic stable,
  output logic rise
);

  // DEB_CYCLES-1 always fits in $clog2(DEB_CYCLES) bits when DEB_CYCLES >= 2.
  localparam int              CNT_W   = $clog2(DEB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced;
  logic [CNT_W-1:0]       cnt;
  logic                   prev_q;

  assign synced = sync_q[SYNC_STAGES-1];

  // Synchroniser chain: shift the asynchronous raw level towards the clock domain.
  always_ff @(posedge clk) begin
    // NOTE: every register in this design is written with <= so all flops
    // sample the pre-edge values together; a blocking = here would collapse
    // the synchroniser chain into a single stage.
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
    end
  end

  // Debouncer: count consecutive cycles of disagreement, accept at the limit.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      stable <= 1'b0;
    end else if (synced == stable) begin
      cnt <= '0;
    end else if (cnt == CNT_MAX) begin
      stable <= synced;
      cnt    <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Previous accepted level, used to find the rising edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= stable;
    end
  end

  // Both operands are registers, so no raw input reaches 'rise' combinationally.
  assign rise = stable & ~prev_q;

endmodule : btn_debounce

// File: rtl/stopwatch_btn_ctrl.sv
// Button and switch conditioning in front of the stopwatch counter.
// Four debouncers clean the raw inputs; the pause button toggles a latched
// pause state, and the reset button produces a one-cycle reset request that
// also forces the stopwatch back to running.
// Optional build macro PAUSE_ON_ADJ_EN: while the debounced adjust switch is
// on, the pause indicator is forced high and pause presses are ignored.
module stopwatch_btn_ctrl
  import stopwatch_pkg::*;
#(
  parameter int DEB_CYCLES  = DEB_CYCLES_DEFAULT,
  parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_pause,
  input  logic btn_rst,
  input  logic sw_adj,
  input  logic sw_sel,
  output logic indicator_pa,
  output logic rst_pulse,
  output logic ADJ,
  output logic sel
);

  pause_state_e state_q;

  logic pause_stable;
  logic pause_rise;
  logic rst_stable;
  logic rst_rise;
  logic adj_stable;
  logic sel_stable;
  logic pause_rise_eff;

  // Rising edges of the switches are not needed by the stopwatch.
  logic unused_adj_rise;
  logic unused_sel_rise;
  logic unused_pause_stable;
  logic unused_rst_stable;

  assign unused_pause_stable = pause_stable;
  assign unused_rst_stable   = rst_stable;

  btn_debounce #(
    .DEB_CYCLES  (DEB_CYCLES),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_deb_pause (
    .clk    (clk),
    .reset  (reset),
    .raw    (btn_pause),
    .stable (pause_stable),
    .rise   (pause_rise)
  );

  btn_debounce #(
    .DEB_CYCLES  (DEB_CYCLES),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_deb_rst (
    .clk    (clk),
    .reset  (reset),
    .raw    (btn_rst),
    .stable (rst_stable),
    .rise   (rst_rise)
  );

  btn_debounce #(
    .DEB_CYCLES  (DEB_CYCLES),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_deb_adj (
    .clk    (clk),
    .reset  (reset),
    .raw    (sw_adj),
    .stable (adj_stable),
    .rise   (unused_adj_rise)
  );

  btn_debounce #(
    .DEB_CYCLES  (DEB_CYCLES),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_deb_sel (
    .clk    (clk),
    .reset  (reset),
    .raw    (sw_sel),
    .stable (sel_stable),
    .rise   (unused_sel_rise)
  );

`ifdef PAUSE_ON_ADJ_EN
  // Adjust mode freezes the pause FSM against pause presses.
  assign pause_rise_eff = pause_rise & ~adj_stable;
`else
  assign pause_rise_eff = pause_rise;
`endif

  // Pause FSM and reset request: reset edge wins over a simultaneous pause edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= RUN;
      rst_pulse <= 1'b0;
    end else begin
      rst_pulse <= rst_rise;
      if (rst_rise) begin
        state_q <= RUN;
      end else if (pause_rise_eff) begin
        state_q <= (state_q == RUN) ? PAUSED : RUN;
      end
    end
  end

`ifdef PAUSE_ON_ADJ_EN
  // Both terms are flops, so the indicator still has no input-to-output path.
  assign indicator_pa = (state_q == PAUSED) | adj_stable;
`else
  assign indicator_pa = (state_q == PAUSED);
`endif

  assign ADJ = adj_stable;
  assign sel = sel_stable;

endmodule : stopwatch_btn_ctrl

// File: tb/tb_stopwatch_btn_ctrl.sv
// Self-checking bench for stopwatch_btn_ctrl with a short debounce window.
// The reference model keeps a short history of raw samples per input and
// accepts a new level once the last DEB synchronised samples all disagree
// with the accepted one; edges, reset requests and the pause toggle follow.
module tb_stopwatch_btn_ctrl;
  import stopwatch_pkg::*;

  localparam int DEB  = DEB_CYCLES_SIM;
  localparam int SYNC = 2;
`ifdef PAUSE_ON_ADJ_EN
  localparam bit FEAT = 1'b1;
`else
  localparam bit FEAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic btn_pause, btn_rst, sw_adj, sw_sel;
  logic indicator_pa, rst_pulse, ADJ, sel;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stopwatch_btn_ctrl #(
    .DEB_CYCLES  (DEB),
    .SYNC_STAGES (SYNC)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .btn_pause    (btn_pause),
    .btn_rst      (btn_rst),
    .sw_adj       (sw_adj),
    .sw_sel       (sw_sel),
    .indicator_pa (indicator_pa),
    .rst_pulse    (rst_pulse),
    .ADJ          (ADJ),
    .sel          (sel)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Index 0 pause, 1 reset button, 2 adjust, 3 select.
  bit raw_q [4][$];
  bit cur   [4];
  bit prv   [4];
  bit m_paused;
  bit m_pulse;

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      raw_q[i] = {};
      for (int k = 0; k < SYNC + DEB; k++) raw_q[i].push_back(1'b0);
      cur[i] = 1'b0;
      prv[i] = 1'b0;
    end
    m_paused = 1'b0;
    m_pulse  = 1'b0;
  endtask

  task automatic model_edge(input logic [3:0] raw_v);
    bit nxt [4];
    bit rise_p, rise_r;
    for (int i = 0; i < 4; i++) begin
      bit flip = 1'b1;
      // raw_q[i][k] is the synchronised sample seen k cycles into the window.
      for (int k = 1; k <= DEB; k++)
        if (raw_q[i][k] == cur[i]) flip = 1'b0;
      nxt[i] = flip ? ~cur[i] : cur[i];
      raw_q[i].push_back(raw_v[i]);
      void'(raw_q[i].pop_front());
    end
    rise_p  = cur[0] & ~prv[0];
    rise_r  = cur[1] & ~prv[1];
    m_pulse = rise_r;
    if (rise_r) m_paused = 1'b0;
    else if (rise_p && !(FEAT && cur[2])) m_paused = ~m_paused;
    for (int i = 0; i < 4; i++) begin
      prv[i] = cur[i];
      cur[i] = nxt[i];
    end
  endtask

  // One clock: advance the model with the inputs seen at the edge, then compare.
  task automatic step();
    logic [3:0] raw_v;
    logic       rst_v;
    raw_v = {sw_sel, sw_adj, btn_rst, btn_pause};
    rst_v = reset;
    @(posedge clk);
    if (rst_v) model_reset();
    else       model_edge(raw_v);
    #1;
    check("indicator_pa", indicator_pa, m_paused | (FEAT & cur[2]));
    check("rst_pulse",    rst_pulse,    m_pulse);
    check("ADJ",          ADJ,          cur[2]);
    check("sel",          sel,          cur[3]);
  endtask

  // Count clocks until indicator_pa changes; a missing change counts as 50.
  task automatic measure_toggle(input string tag, input int exp_cycles);
    logic start;
    int   n;
    start = indicator_pa;
    n = 0;
    while (indicator_pa === start && n < 50) begin
      step();
      n++;
    end
    check(tag, n, exp_cycles);
  endtask

  int pulses;
  int max_cnt;
  logic ind_at_pulse;
  int n_adj;

  initial begin
    reset = 1'b1; btn_pause = 0; btn_rst = 0; sw_adj = 0; sw_sel = 0;
    model_reset();

    // Reset state.
    repeat (3) step();
    check("reset_fsm_run", dut.state_q, RUN);
    reset = 1'b0;
    repeat (3) step();

    // Pause press: indicator toggles 7 clocks after the press, latches after release.
    btn_pause = 1'b1;
    measure_toggle("pause_latency_1", 7);
    repeat (13) step();
    btn_pause = 1'b0;
    repeat (12) step();
    check("pause_latched", indicator_pa, 1);
    btn_pause = 1'b1;
    measure_toggle("pause_latency_2", 7);
    repeat (13) step();
    btn_pause = 1'b0;
    repeat (12) step();
    check("pause_returned", indicator_pa, 0);

    // Bouncing reset button never gets through.
    pulses = 0; max_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      btn_rst = (i % 2 == 0);
      step();
      if (rst_pulse) pulses++;
      if (int'(dut.u_deb_rst.cnt) > max_cnt) max_cnt = int'(dut.u_deb_rst.cnt);
    end
    btn_rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (rst_pulse) pulses++;
      if (int'(dut.u_deb_rst.cnt) > max_cnt) max_cnt = int'(dut.u_deb_rst.cnt);
    end
    check("glitch_no_pulse", pulses, 0);
    check("glitch_cnt_below_limit", (max_cnt >= DEB - 1), 0);

    // Paused, then pause and reset pressed together: reset wins.
    btn_pause = 1'b1;
    measure_toggle("pause_before_both", 7);
    btn_pause = 1'b0;
    repeat (10) step();
    pulses = 0; ind_at_pulse = 1'b1;
    btn_pause = 1'b1; btn_rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (rst_pulse) begin
        pulses++;
        ind_at_pulse = indicator_pa;
      end
    end
    btn_pause = 1'b0; btn_rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (rst_pulse) pulses++;
    end
    check("both_single_pulse", pulses, 1);
    check("both_reset_wins", ind_at_pulse, 0);

    // Adjust switch: level accepted after SYNC + DEB clocks, then a pause press.
    sw_adj = 1'b1;
    n_adj = 0;
    while (ADJ !== 1'b1 && n_adj < 50) begin
      step();
      n_adj++;
    end
    check("adj_latency", n_adj, SYNC + DEB);
    btn_pause = 1'b1;
    repeat (10) step();
    check("adj_pause_effect", indicator_pa, 1);
    btn_pause = 1'b0; sw_adj = 1'b0;
    repeat (12) step();

    // Reset while the pause press is mid-count: the partial count is discarded.
    reset = 1'b1; step(); reset = 1'b0; repeat (2) step();
    btn_pause = 1'b1;
    repeat (4) step();
    check("midcount_cnt", dut.u_deb_pause.cnt, 2);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midcount_cleared", dut.u_deb_pause.cnt, 0);
    measure_toggle("midcount_relatency", 7);
    btn_pause = 1'b0;
    repeat (12) step();

    // Randomised segments against the model.
    for (int seg = 0; seg < 1200; seg++) begin
      if ($urandom_range(0, 39) == 0) begin
        reset = 1'b1;
        step();
        reset = 1'b0;
      end
      if ($urandom_range(0, 2) == 0) btn_pause = ~btn_pause;
      if ($urandom_range(0, 3) == 0) btn_rst   = ~btn_rst;
      if ($urandom_range(0, 4) == 0) sw_adj    = ~sw_adj;
      if ($urandom_range(0, 3) == 0) sw_sel    = ~sw_sel;
      repeat ($urandom_range(1, 10)) step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_stopwatch_btn_ctrl
